// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared definitions for the sequential digit comparator: FSM state
// encoding and helpers that size the digit counter from the operand width.
package cmp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of 2-bit digits in a W-bit operand.
    function automatic int digits_of(input int w);
        return w / 2;
    endfunction

    // Digit counter width; never narrower than one bit so W=2 still has a counter.
    function automatic int cnt_width(input int w);
        int c;
        c = $clog2(w / 2);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/cmp_seq_ctrl_cmp2b.sv
// Combinational 2-bit unsigned comparator; the only compare datapath used
// by the sequential controller. Exactly one of eq/lt/gt is high.
module cmp2b (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       eq,
    output logic       lt,
    output logic       gt
);

    assign eq = (x == y);
    assign lt = (x < y);
    assign gt = (x > y);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequential W-bit unsigned comparator. Operands are captured on an accepted
// start and fed through the 2-bit comparator one digit per cycle, MSB digit
// first. The one-hot eq/lt/gt result is published together with a one-cycle
// done pulse and holds until the next accepted start.
//
// Handshake: start is a request sampled only while idle (busy=0, done=0);
// it is accepted on the rising edge where the FSM is in IDLE and start=1.
// Requests while busy or during the done cycle are dropped, not queued.
// done is a single-cycle strobe; eq/lt/gt are valid from that cycle until
// the next accepted start, and read 0 while busy.
module cmp_seq_ctrl
    import cmp_seq_pkg::*;
#(
    parameter int W          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    localparam int             DIGITS   = digits_of(W);
    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  CNT_INIT = CW'(DIGITS - 1);

    state_t        state;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          decided;
    logic          dec_lt;
    logic          dec_gt;

    logic          d_eq;
    logic          d_lt;
    logic          d_gt;
    logic          digit_diff;
    logic          take_new;
    logic          nxt_decided;
    logic          nxt_lt;
    logic          nxt_gt;
    logic          last_digit;

    // The current MSB digit of each shift register is the comparator input.
    cmp2b u_cmp2b (
        .x  (sa[W-1:W-2]),
        .y  (sb[W-1:W-2]),
        .eq (d_eq),
        .lt (d_lt),
        .gt (d_gt)
    );

    // First unequal digit decides the result; later digits cannot override it.
    always_comb begin
        digit_diff  = ~d_eq;
        take_new    = ~decided & digit_diff;
        nxt_decided = decided | digit_diff;
        nxt_lt      = take_new ? d_lt : dec_lt;
        nxt_gt      = take_new ? d_gt : dec_gt;
        last_digit  = (cnt == '0) | (EARLY_EXIT & digit_diff);
    end

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dec_lt  <= 1'b0;
            dec_gt  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        cnt     <= CNT_INIT;
                        decided <= 1'b0;
                        dec_lt  <= 1'b0;
                        dec_gt  <= 1'b0;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                        gt      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    decided <= nxt_decided;
                    dec_lt  <= nxt_lt;
                    dec_gt  <= nxt_gt;
                    if (last_digit) begin
                        // Result becomes visible in the same cycle as done.
                        eq    <= ~nxt_decided;
                        lt    <= nxt_lt;
                        gt    <= nxt_gt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        sa  <= sa << 2;
                        sb  <= sb << 2;
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
